// File: rtl/alu_multicycle.sv
// Slice-serial ALU: add/sub/slt walk SLICE bits per clock from the LSB, logic ops take one cycle.
// Operands and results move through valid/ready handshakes; one operation is in flight at a time.
module alu_multicycle #(
   parameter int WIDTH = 32,
   parameter int SLICE = 8
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] operandA,
   input  logic [WIDTH-1:0] operandB,
   input  logic [2:0]       command,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] result,
   output logic             carryout,
   output logic             zero,
   output logic             overflow
);

   localparam int NSL = (SLICE > 0) ? (WIDTH / SLICE) : 1;
   localparam int CW  = (NSL > 1) ? $clog2(NSL) : 1;
   localparam logic [CW-1:0] LAST_SLICE = CW'(NSL - 1);

   localparam logic [2:0] CMD_ADD  = 3'd0;
   localparam logic [2:0] CMD_SUB  = 3'd1;
   localparam logic [2:0] CMD_XOR  = 3'd2;
   localparam logic [2:0] CMD_SLT  = 3'd3;
   localparam logic [2:0] CMD_AND  = 3'd4;
   localparam logic [2:0] CMD_NAND = 3'd5;
   localparam logic [2:0] CMD_NOR  = 3'd6;
   localparam logic [2:0] CMD_OR   = 3'd7;

   if ((WIDTH < 2) || (SLICE < 1) || ((WIDTH % SLICE) != 0)) begin : g_param_check
      $error("alu_multicycle: WIDTH must be >= 2 and an exact multiple of SLICE");
   end

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_CALC = 2'd1,
      ST_DONE = 2'd2
   } state_t;

   state_t           state_q, state_d;
   logic [WIDTH-1:0] a_q, a_d;
   logic [WIDTH-1:0] b_q, b_d;
   logic [2:0]       cmd_q, cmd_d;
   logic             carry_q, carry_d;
   logic [CW-1:0]    cnt_q, cnt_d;
   logic [WIDTH-1:0] result_q, result_d;
   logic             carryout_q, carryout_d;
   logic             zero_q, zero_d;
   logic             overflow_q, overflow_d;

   logic [31:0]      slice_base_s;
   logic             sub_mode_s;
   logic [SLICE-1:0] slice_a_s;
   logic [SLICE-1:0] slice_b_s;
   logic [SLICE:0]   slice_sum_s;
   logic             slice_ovf_s;
   logic [WIDTH-1:0] arith_res_s;
   logic [WIDTH-1:0] logic_res_s;
   logic [WIDTH-1:0] final_res_s;
   logic             is_arith_s;

   assign slice_base_s = 32'(cnt_q) * 32'(SLICE);
   assign sub_mode_s   = (cmd_q == CMD_SUB) || (cmd_q == CMD_SLT);
   assign is_arith_s   = (cmd_q == CMD_ADD) || sub_mode_s;

   // One slice of A + (B or ~B) + carry; overflow uses the sign rule, valid on the MSB slice.
   always_comb begin
      slice_a_s   = a_q[slice_base_s +: SLICE];
      slice_b_s   = b_q[slice_base_s +: SLICE] ^ {SLICE{sub_mode_s}};
      slice_sum_s = {1'b0, slice_a_s} + {1'b0, slice_b_s} + {{SLICE{1'b0}}, carry_q};
      slice_ovf_s = (slice_a_s[SLICE-1] == slice_b_s[SLICE-1]) &&
                    (slice_sum_s[SLICE-1] != slice_a_s[SLICE-1]);
      arith_res_s = result_q;
      arith_res_s[slice_base_s +: SLICE] = slice_sum_s[SLICE-1:0];
   end

   // Full-width logic operations on the latched operands.
   always_comb begin
      case (cmd_q)
         CMD_XOR:  logic_res_s = a_q ^ b_q;
         CMD_AND:  logic_res_s = a_q & b_q;
         CMD_NAND: logic_res_s = ~(a_q & b_q);
         CMD_NOR:  logic_res_s = ~(a_q | b_q);
         CMD_OR:   logic_res_s = a_q | b_q;
         default:  logic_res_s = {WIDTH{1'b0}};
      endcase
   end

   // Next-state and datapath update for the IDLE -> CALC -> DONE handshake sequence.
   always_comb begin
      state_d     = state_q;
      a_d         = a_q;
      b_d         = b_q;
      cmd_d       = cmd_q;
      carry_d     = carry_q;
      cnt_d       = cnt_q;
      result_d    = result_q;
      carryout_d  = carryout_q;
      zero_d      = zero_q;
      overflow_d  = overflow_q;
      final_res_s = {WIDTH{1'b0}};
      case (state_q)
         ST_IDLE: begin
            if (in_valid) begin
               a_d     = operandA;
               b_d     = operandB;
               cmd_d   = command;
               carry_d = (command == CMD_SUB) || (command == CMD_SLT);
               cnt_d   = {CW{1'b0}};
               state_d = ST_CALC;
            end else begin
               state_d = ST_IDLE;
            end
         end
         ST_CALC: begin
            if (is_arith_s) begin
               carry_d  = slice_sum_s[SLICE];
               result_d = arith_res_s;
               if (cnt_q == LAST_SLICE) begin
                  // SLT reports only the sign-corrected comparison bit, never raw flags.
                  if (cmd_q == CMD_SLT) begin
                     final_res_s = {{(WIDTH-1){1'b0}}, slice_sum_s[SLICE-1] ^ slice_ovf_s};
                     carryout_d  = 1'b0;
                     overflow_d  = 1'b0;
                  end else begin
                     final_res_s = arith_res_s;
                     carryout_d  = slice_sum_s[SLICE];
                     overflow_d  = slice_ovf_s;
                  end
                  result_d = final_res_s;
                  zero_d   = (final_res_s == {WIDTH{1'b0}});
                  cnt_d    = {CW{1'b0}};
                  state_d  = ST_DONE;
               end else begin
                  cnt_d   = cnt_q + CW'(1);
                  state_d = ST_CALC;
               end
            end else begin
               final_res_s = logic_res_s;
               result_d    = final_res_s;
               carryout_d  = 1'b0;
               overflow_d  = 1'b0;
               zero_d      = (final_res_s == {WIDTH{1'b0}});
               cnt_d       = {CW{1'b0}};
               state_d     = ST_DONE;
            end
         end
         ST_DONE: begin
            if (out_ready) begin
               state_d = ST_IDLE;
            end else begin
               state_d = ST_DONE;
            end
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   // State, operand latches and result/flag registers.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q    <= ST_IDLE;
         a_q        <= {WIDTH{1'b0}};
         b_q        <= {WIDTH{1'b0}};
         cmd_q      <= 3'd0;
         carry_q    <= 1'b0;
         cnt_q      <= {CW{1'b0}};
         result_q   <= {WIDTH{1'b0}};
         carryout_q <= 1'b0;
         zero_q     <= 1'b0;
         overflow_q <= 1'b0;
      end else begin
         state_q    <= state_d;
         a_q        <= a_d;
         b_q        <= b_d;
         cmd_q      <= cmd_d;
         carry_q    <= carry_d;
         cnt_q      <= cnt_d;
         result_q   <= result_d;
         carryout_q <= carryout_d;
         zero_q     <= zero_d;
         overflow_q <= overflow_d;
      end
   end

   assign in_ready  = (state_q == ST_IDLE);
   assign out_valid = (state_q == ST_DONE);
   assign result    = result_q;
   assign carryout  = carryout_q;
   assign zero      = zero_q;
   assign overflow  = overflow_q;

endmodule

// File: tb/tb_alu_multicycle.sv
// Self-checking bench for alu_multicycle: a SLICE=8 instance and a SLICE=32 instance share
// clock, reset and operand buses; each has its own handshake signals.
module tb_alu_multicycle;

   typedef struct {
      string       name;
      logic [2:0]  cmd;
      logic [31:0] a;
      logic [31:0] b;
      logic [31:0] res;
      logic        co;
      logic        z;
      logic        ov;
      int          lat;
   } vec_t;

   logic        clk;
   logic        reset;
   logic [31:0] opa;
   logic [31:0] opb;
   logic [2:0]  cmd;
   logic [1:0]  in_valid_v;
   logic [1:0]  in_ready_v;
   logic [1:0]  out_valid_v;
   logic [1:0]  out_ready_v;
   logic [1:0]  co_v;
   logic [1:0]  z_v;
   logic [1:0]  ov_v;
   logic [31:0] res_v [2];

   int checks;
   int failures;
   vec_t exp_q[$];
   vec_t tbl[$];

   alu_multicycle #(.WIDTH(32), .SLICE(8)) dut (
      .clk(clk), .reset(reset),
      .in_valid(in_valid_v[0]), .in_ready(in_ready_v[0]),
      .operandA(opa), .operandB(opb), .command(cmd),
      .out_valid(out_valid_v[0]), .out_ready(out_ready_v[0]),
      .result(res_v[0]), .carryout(co_v[0]), .zero(z_v[0]), .overflow(ov_v[0])
   );

   alu_multicycle #(.WIDTH(32), .SLICE(32)) dut32 (
      .clk(clk), .reset(reset),
      .in_valid(in_valid_v[1]), .in_ready(in_ready_v[1]),
      .operandA(opa), .operandB(opb), .command(cmd),
      .out_valid(out_valid_v[1]), .out_ready(out_ready_v[1]),
      .result(res_v[1]), .carryout(co_v[1]), .zero(z_v[1]), .overflow(ov_v[1])
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
      end
   endtask

   function automatic vec_t mk(input string name, input logic [2:0] c, input logic [31:0] a,
                               input logic [31:0] b, input logic [31:0] res, input logic co,
                               input logic z, input logic ov, input int lat);
      vec_t v;
      v.name = name; v.cmd = c; v.a = a; v.b = b; v.res = res;
      v.co = co; v.z = z; v.ov = ov; v.lat = lat;
      return v;
   endfunction

   // Drive one operation, check latency, pop the scoreboard on out_valid, optionally stall.
   task automatic run_op(input int sel, input vec_t v, input int hold);
      vec_t e;
      int   edges;
      @(negedge clk);
      chk({v.name, " in_ready before"}, {31'd0, in_ready_v[sel]}, 32'd1);
      opa = v.a; opb = v.b; cmd = v.cmd;
      in_valid_v[sel] = 1'b1;
      @(posedge clk); #1;
      in_valid_v[sel] = 1'b0;
      opa = ~v.a; opb = ~v.b; cmd = v.cmd ^ 3'd1;
      exp_q.push_back(v);
      chk({v.name, " in_ready busy"}, {31'd0, in_ready_v[sel]}, 32'd0);
      edges = 0;
      while (!out_valid_v[sel] && edges < 20) begin
         @(posedge clk); #1;
         edges++;
      end
      chk({v.name, " latency"}, 32'(edges), 32'(v.lat));
      if (out_valid_v[sel] && exp_q.size() > 0) begin
         e = exp_q.pop_front();
         chk({e.name, " result"}, res_v[sel], e.res);
         chk({e.name, " carryout"}, {31'd0, co_v[sel]}, {31'd0, e.co});
         chk({e.name, " zero"}, {31'd0, z_v[sel]}, {31'd0, e.z});
         chk({e.name, " overflow"}, {31'd0, ov_v[sel]}, {31'd0, e.ov});
         for (int h = 0; h < hold; h++) begin
            @(posedge clk); #1;
            chk({e.name, " held result"}, res_v[sel], e.res);
            chk({e.name, " held flags"}, {29'd0, co_v[sel], z_v[sel], ov_v[sel]},
                {29'd0, e.co, e.z, e.ov});
            chk({e.name, " held out_valid"}, {31'd0, out_valid_v[sel]}, 32'd1);
            chk({e.name, " held in_ready"}, {31'd0, in_ready_v[sel]}, 32'd0);
         end
      end else begin
         exp_q.delete();
      end
      @(negedge clk);
      out_ready_v[sel] = 1'b1;
      @(posedge clk); #1;
      out_ready_v[sel] = 1'b0;
      chk({v.name, " released out_valid"}, {31'd0, out_valid_v[sel]}, 32'd0);
      chk({v.name, " released in_ready"}, {31'd0, in_ready_v[sel]}, 32'd1);
   endtask

   initial begin
      checks = 0; failures = 0;
      reset = 1'b1;
      opa = 32'd0; opb = 32'd0; cmd = 3'd0;
      in_valid_v = 2'b00; out_ready_v = 2'b00;

      tbl.push_back(mk("add_ovf",   3'd0, 32'h7FFFFFFF, 32'h00000001, 32'h80000000, 1'b0, 1'b0, 1'b1, 4));
      tbl.push_back(mk("sub_eq",    3'd1, 32'h00000005, 32'h00000005, 32'h00000000, 1'b1, 1'b1, 1'b0, 4));
      tbl.push_back(mk("add_wrap",  3'd0, 32'hFFFFFFFF, 32'h00000001, 32'h00000000, 1'b1, 1'b1, 1'b0, 4));
      tbl.push_back(mk("slt_neg",   3'd3, 32'hFFFFFFFF, 32'h00000001, 32'h00000001, 1'b0, 1'b0, 1'b0, 4));
      tbl.push_back(mk("slt_ovf",   3'd3, 32'h7FFFFFFF, 32'h80000000, 32'h00000000, 1'b0, 1'b1, 1'b0, 4));
      tbl.push_back(mk("and",       3'd4, 32'hF0F0F0F0, 32'hFF00FF00, 32'hF000F000, 1'b0, 1'b0, 1'b0, 1));
      tbl.push_back(mk("nor_zero",  3'd6, 32'h00000000, 32'h00000000, 32'hFFFFFFFF, 1'b0, 1'b0, 1'b0, 1));
      tbl.push_back(mk("xor",       3'd2, 32'hA5A5A5A5, 32'hFFFF0000, 32'h5A5AA5A5, 1'b0, 1'b0, 1'b0, 1));
      tbl.push_back(mk("nand_ones", 3'd5, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000000, 1'b0, 1'b1, 1'b0, 1));
      tbl.push_back(mk("or",        3'd7, 32'h12340000, 32'h00005678, 32'h12345678, 1'b0, 1'b0, 1'b0, 1));
      tbl.push_back(mk("sub_borrow",3'd1, 32'h00000003, 32'h0000000A, 32'hFFFFFFF9, 1'b0, 1'b0, 1'b0, 4));
      tbl.push_back(mk("sub_ovf",   3'd1, 32'h80000000, 32'h00000001, 32'h7FFFFFFF, 1'b1, 1'b0, 1'b1, 4));
      tbl.push_back(mk("slt_pos",   3'd3, 32'h00000003, 32'h0000000A, 32'h00000001, 1'b0, 1'b0, 1'b0, 4));
      tbl.push_back(mk("add_chain", 3'd0, 32'h00FF00FF, 32'h00010001, 32'h01000100, 1'b0, 1'b0, 1'b0, 4));

      repeat (2) @(negedge clk);
      reset = 1'b0;
      #1;
      chk("reset in_ready", {31'd0, in_ready_v[0]}, 32'd1);
      chk("reset out_valid", {31'd0, out_valid_v[0]}, 32'd0);
      chk("reset result", res_v[0], 32'd0);
      chk("reset flags", {29'd0, co_v[0], z_v[0], ov_v[0]}, 32'd0);

      foreach (tbl[i]) run_op(0, tbl[i], 0);

      // Backpressure: three stalled cycles in DONE, then an immediate follow-on op.
      run_op(0, mk("bp_add", 3'd0, 32'h00000001, 32'h00000002, 32'h00000003, 1'b0, 1'b0, 1'b0, 4), 3);
      run_op(0, mk("bp_next_or", 3'd7, 32'h0000000F, 32'h000000F0, 32'h000000FF, 1'b0, 1'b0, 1'b0, 1), 0);

      // Reset asserted mid-way through an ADD must abort it without a clock edge.
      @(negedge clk);
      opa = 32'h11111111; opb = 32'h22222222; cmd = 3'd0; in_valid_v[0] = 1'b1;
      @(posedge clk); #1;
      in_valid_v[0] = 1'b0;
      @(posedge clk);
      @(posedge clk); #2;
      chk("abort pre in_ready", {31'd0, in_ready_v[0]}, 32'd0);
      reset = 1'b1;
      #1;
      chk("abort out_valid", {31'd0, out_valid_v[0]}, 32'd0);
      chk("abort in_ready", {31'd0, in_ready_v[0]}, 32'd1);
      chk("abort result", res_v[0], 32'd0);
      chk("abort flags", {29'd0, co_v[0], z_v[0], ov_v[0]}, 32'd0);
      @(negedge clk);
      reset = 1'b0;
      run_op(0, mk("post_abort_sub", 3'd1, 32'd10, 32'd3, 32'd7, 1'b1, 1'b0, 1'b0, 4), 0);

      // Full-width slice: arithmetic finishes in a single CALC cycle.
      run_op(1, mk("s32_add_ovf", 3'd0, 32'h7FFFFFFF, 32'h00000001, 32'h80000000, 1'b0, 1'b0, 1'b1, 1), 0);
      run_op(1, mk("s32_sub_eq", 3'd1, 32'h00000005, 32'h00000005, 32'h00000000, 1'b1, 1'b1, 1'b0, 1), 0);
      run_op(1, mk("s32_slt_ovf", 3'd3, 32'h7FFFFFFF, 32'h80000000, 32'h00000000, 1'b0, 1'b1, 1'b0, 1), 0);

      chk("scoreboard drained", 32'(exp_q.size()), 32'd0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
